// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module  : wb_regfile
// Brief   : Writeback-stage source select, 32x32 register file with bypassed
//           read ports, sticky halt / select-error flags and retire counter.
// Revision: 1.0
// ============================================================================
module wb_regfile #(
    parameter bit          BYPASS = 1'b1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             wb_valid,
    input  logic [31:0]      wb_npc,
    input  logic [31:0]      wb_curr_pc,
    input  logic [31:0]      wb_port_out,
    input  logic [31:0]      wb_dmemload,
    input  logic [31:0]      wb_zeroExt,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regWr,
    input  logic             wb_halt,
    input  logic [2:0]       wb_rdSel,
    input  logic [4:0]       rsel1,
    input  logic [4:0]       rsel2,
    output logic [31:0]      rdat1,
    output logic [31:0]      rdat2,
    output logic [31:0]      wdat_o,
    output logic             wen_o,
    output logic             halt_o,
    output logic             sel_err_o,
    output logic [CNT_W-1:0] retired_o
);

    logic [31:0]      regs_q [32];
    logic             halt_q;
    logic             halt_d;
    logic             sel_err_q;
    logic             sel_err_d;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] retired_d;

    always_comb begin
        wdat_o = '0;
        unique case (wb_rdSel)
            3'd0:    wdat_o = wb_port_out;
            3'd1:    wdat_o = wb_dmemload;
            3'd2:    wdat_o = wb_npc;
            3'd3:    wdat_o = wb_zeroExt;
            3'd4:    wdat_o = wb_curr_pc + wb_zeroExt;
            default: wdat_o = '0;
        endcase
    end

    assign wen_o = wb_valid & wb_regWr & (wb_rd != 5'd0) & ~halt_q & (wb_rdSel <= 3'd4);

    // Halt blocks everything after itself; the halt instruction is still counted.
    always_comb begin
        halt_d    = halt_q;
        sel_err_d = sel_err_q;
        retired_d = retired_q;
        if (!halt_q) begin
            if (wb_valid && wb_halt)
                halt_d = 1'b1;
            if (wb_valid && wb_regWr && (wb_rdSel > 3'd4))
                sel_err_d = 1'b1;
            if (wb_valid)
                retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 32; i++)
                regs_q[i] <= '0;
            halt_q    <= 1'b0;
            sel_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            if (wen_o)
                regs_q[wb_rd] <= wdat_o;
            halt_q    <= halt_d;
            sel_err_q <= sel_err_d;
            retired_q <= retired_d;
        end
    end

    // wen_o already excludes x0, so a bypass hit never targets register 0.
    always_comb begin
        rdat1 = '0;
        if (rsel1 != 5'd0) begin
            if (BYPASS && wen_o && (rsel1 == wb_rd))
                rdat1 = wdat_o;
            else
                rdat1 = regs_q[rsel1];
        end
    end

    always_comb begin
        rdat2 = '0;
        if (rsel2 != 5'd0) begin
            if (BYPASS && wen_o && (rsel2 == wb_rd))
                rdat2 = wdat_o;
            else
                rdat2 = regs_q[rsel2];
        end
    end

    assign halt_o    = halt_q;
    assign sel_err_o = sel_err_q;
    assign retired_o = retired_q;

endmodule
`default_nettype wire
